press_gen: RTL and testbench

- Transmit-side counterpart of the button debounce/pulse FSM.
- Converts single-cycle request pulses into emulated button presses: `bo` is held high for PRESS_LEN cycles, then forced low for at least GAP_LEN cycles.
- Requests that arrive while a press is in progress are queued in a saturating pending counter.
- Used to drive button-style inputs from internal logic and to stimulate the press-detect FSM in system tests.

---
 rtl/press_gen.sv | 160 ++++++++++++++++
 tb/tb_press_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_gen.sv
// press_gen: turns single-cycle request pulses into emulated button presses.
//
// Each accepted request drives `bo` high for PRESS_LEN cycles, then holds it
// low for at least GAP_LEN cycles. Requests that arrive while a press or gap
// is in progress are queued in a saturating counter. A request that finds the
// queue full is dropped, and the sticky `ovf` flag is set.
//
// Optional feature, selected by the macro PRESS_GEN_CNT_EN:
//   When it is defined, the module adds the 8-bit `press_cnt` output. This
//   counter increments on every entry into PRESS and wraps from 255 to 0.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset
//   pi        in   request pulse; each cycle sampled high is one request
//   bo        out  emulated button level (registered)
//   busy      out  high while a press/gap is active or requests are queued
//   pend      out  number of queued requests
//   ovf       out  sticky overflow flag; set when a request is dropped
//   press_cnt out  presses started, mod 256 (PRESS_GEN_CNT_EN only)
module press_gen #(
    parameter int unsigned PRESS_LEN = 4,
    parameter int unsigned GAP_LEN   = 2,
    parameter int unsigned PEND_MAX  = 3,
    parameter int unsigned PEND_W    = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pi,
    output logic              bo,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
`ifdef PRESS_GEN_CNT_EN
    ,
    output logic [7:0]        press_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap
    } state_e;

    localparam logic [CNT_W-1:0]  PressLoad = CNT_W'(PRESS_LEN - 1);
    localparam logic [CNT_W-1:0]  GapLoad   = CNT_W'(GAP_LEN - 1);
    localparam logic [PEND_W-1:0] PendMax   = PEND_W'(PEND_MAX);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                bo_q, bo_d;
    logic                enter_press;

    // Next-state and countdown logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_press = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pi) begin
                    state_d     = StPress;
                    cnt_d       = PressLoad;
                    enter_press = 1'b1;
                end
            end
            StPress: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if ((pend_q != '0) || pi) begin
                    state_d     = StPress;
                    cnt_d       = PressLoad;
                    enter_press = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Request accounting. A request that coincides with a press start is
    // consumed in the same edge, so the queue depth stays unchanged. A press
    // start without a new request occurs only from GAP with pend != 0, so
    // the decrement cannot underflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (pi && !enter_press) begin
            if (pend_q < PendMax) begin
                pend_d = pend_q + PEND_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (!pi && enter_press) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    // bo is registered from the next state so that it tracks PRESS exactly
    assign bo_d = (state_d == StPress);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            bo_q    <= bo_d;
        end
    end

`ifdef PRESS_GEN_CNT_EN
    logic [7:0] press_cnt_q, press_cnt_d;

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (enter_press) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt_q <= 8'd0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_cnt = press_cnt_q;
`endif

    assign bo   = bo_q;
    assign pend = pend_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != StIdle) || (pend_q != '0);

endmodule

// File: tb/tb_press_gen.sv
// Self-checking bench for press_gen with default parameters.
// Cycle k means the interval after clock edge k. Outputs are sampled at the
// negedge inside cycle k. pi/rst are set at that same negedge, so the
// rising edge that ends cycle k samples them.
module tb_press_gen;

    logic       clk;
    logic       rst;
    logic       pi;
    logic       bo;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
`ifdef PRESS_GEN_CNT_EN
    logic [7:0] press_cnt;
`endif

    int checks;
    int errors;

    typedef struct packed {
        logic       bo;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    press_gen dut (
        .clk  (clk),
        .rst  (rst),
        .pi   (pi),
        .bo   (bo),
        .busy (busy),
        .pend (pend),
        .ovf  (ovf)
`ifdef PRESS_GEN_CNT_EN
        ,
        .press_cnt (press_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presses start at cycles 1, 7, 13, ... : 4 cycles high, then 2 low.
    function automatic logic exp_bo(input int k, input int n);
        return (k >= 1) && (((k - 1) % 6) < 4) && (((k - 1) / 6) < n);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        pi  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset from a busy state that has overflowed: every output clears.
    task automatic test_reset();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            e.bo   = exp_bo(k, 1) && (k <= 6);
            e.busy = (k >= 1) && (k <= 6);
            e.pend = (k == 2) ? 2'd1 : (k == 3) ? 2'd2 : (k >= 4 && k <= 6) ? 2'd3 : 2'd0;
            e.ovf  = (k == 5) || (k == 6);
            sb.push_back(e);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL reset k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi  = (k <= 5);
            rst = (k == 6);
        end
        rst = 1'b0;
        pi  = 1'b0;
    endtask

    task automatic test_single_pulse();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            e.bo   = exp_bo(k, 1);
            e.busy = (k >= 1) && (k <= 6);
            e.pend = 2'd0;
            e.ovf  = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL single k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi = (k == 0);
        end
        pi = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            e.bo   = exp_bo(k, 2);
            e.busy = (k >= 1) && (k <= 12);
            e.pend = (k >= 2 && k <= 6) ? 2'd1 : 2'd0;
            e.ovf  = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL b2b k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi = (k <= 1);
        end
        pi = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 28; k++) begin
            e.bo   = exp_bo(k, 4);
            e.busy = (k >= 1) && (k <= 24);
            e.pend = (k == 2) ? 2'd1 : (k == 3) ? 2'd2 : (k >= 4 && k <= 6) ? 2'd3 :
                     (k >= 7 && k <= 12) ? 2'd2 : (k >= 13 && k <= 18) ? 2'd1 : 2'd0;
            e.ovf  = (k >= 5);
            sb.push_back(e);
        end
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL overflow k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi = (k <= 4);
        end
        pi = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            e.bo   = (k >= 1 && k <= 2) || (k >= 6 && k <= 9);
            e.busy = (k >= 1 && k <= 2) || (k >= 6 && k <= 11);
            e.pend = 2'd0;
            e.ovf  = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL midreset k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi  = (k == 0) || (k == 5);
            rst = (k == 2);
        end
        pi  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_held();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 46; k++) begin
            e.bo   = exp_bo(k, 7);
            e.busy = (k >= 1) && (k <= 42);
            e.pend = (k == 2) ? 2'd1 : (k == 3) ? 2'd2 : (k >= 4 && k <= 24) ? 2'd3 :
                     (k >= 25 && k <= 30) ? 2'd2 : (k >= 31 && k <= 36) ? 2'd1 : 2'd0;
            e.ovf  = (k >= 5);
            sb.push_back(e);
        end
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bo, busy, pend, ovf} !== {e.bo, e.busy, e.pend, e.ovf}) begin
                errors++;
                $display("FAIL held k=%0d got bo=%b busy=%b pend=%0d ovf=%b exp bo=%b busy=%b pend=%0d ovf=%b",
                         k, bo, busy, pend, ovf, e.bo, e.busy, e.pend, e.ovf);
            end
            pi = (k < 20);
        end
        pi = 1'b0;
    endtask

`ifdef PRESS_GEN_CNT_EN
    task automatic test_press_cnt();
        logic [7:0] q[$];
        logic [7:0] e;
        apply_reset();
        q.push_back(8'd0);
        q.push_back(8'd1);
        q.push_back(8'd1);
        q.push_back(8'd0);
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (press_cnt !== e) begin
            errors++;
            $display("FAIL press_cnt_reset got %0d exp %0d", press_cnt, e);
        end
        for (int p = 0; p < 257; p++) begin
            pi = 1'b1;
            @(negedge clk);
            pi = 1'b0;
            repeat (6) @(negedge clk);
            if (p == 0) begin
                e = q.pop_front();
                checks++;
                if (press_cnt !== e) begin
                    errors++;
                    $display("FAIL press_cnt_first got %0d exp %0d", press_cnt, e);
                end
            end
        end
        e = q.pop_front();
        checks++;
        if (press_cnt !== e) begin
            errors++;
            $display("FAIL press_cnt_wrap got %0d exp %0d", press_cnt, e);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = q.pop_front();
        checks++;
        if (press_cnt !== e) begin
            errors++;
            $display("FAIL press_cnt_clear got %0d exp %0d", press_cnt, e);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pi     = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        test_held();
`ifdef PRESS_GEN_CNT_EN
        test_press_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
